// File: rtl/calc_engine_pkg.sv
// Shared keypad operator codes, FSM state encoding and small helpers for the
// BCD calculator engine and its converters.
package calc_engine_pkg;

  localparam logic [7:0] OP_A_ADD  = 8'h0A;
  localparam logic [7:0] OP_B_SUB  = 8'h0B;
  localparam logic [7:0] OP_F_MULT = 8'h0F;
  localparam logic [7:0] OP_D_IVID = 8'h0D;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    EXEC = 3'd2,
    MUL  = 3'd3,
    DIV  = 3'd4,
    ERR  = 3'd5,
    DONE = 3'd6
  } state_e;

  function automatic logic op_valid(input logic [7:0] code);
    return (code == OP_A_ADD) || (code == OP_B_SUB) ||
           (code == OP_F_MULT) || (code == OP_D_IVID);
  endfunction

  function automatic logic bcd_bad(input logic [3:0] digit);
    return digit > 4'd9;
  endfunction

endpackage

// File: rtl/calc_engine_bcd2bin_seq.sv
// Iterative BCD-to-binary converter: one decimal digit per step, most
// significant digit first, with a sticky flag for non-decimal nibbles.
module bcd2bin_seq
  import calc_engine_pkg::*;
#(
  parameter  int DIGITS = 2,
  localparam int OPW    = $clog2(10 ** DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                step_i,
  input  logic [4*DIGITS-1:0] bcd_i,
  output logic [OPW-1:0]      bin_o,
  output logic [OPW-1:0]      bin_nxt_o,
  output logic                bad_nxt_o
);

  logic [4*DIGITS-1:0] sh_q;
  logic [OPW-1:0]      acc_q;
  logic                bad_q;
  logic [3:0]          digit;

  // The look-ahead outputs let the parent decide its next state during the
  // final conversion step instead of spending an extra cycle.
  always_comb begin
    digit     = sh_q[4*DIGITS-1 -: 4];
    bin_nxt_o = acc_q * OPW'(10) + OPW'(digit);
    bad_nxt_o = bad_q | bcd_bad(digit);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q  <= '0;
      acc_q <= '0;
      bad_q <= 1'b0;
    end else if (load_i) begin
      sh_q  <= bcd_i;
      acc_q <= '0;
      bad_q <= 1'b0;
    end else if (step_i) begin
      sh_q  <= sh_q << 4;
      acc_q <= bin_nxt_o;
      bad_q <= bad_nxt_o;
    end
  end

  assign bin_o = acc_q;

endmodule

// File: rtl/calc_engine.sv
// Multi-cycle BCD calculator: converts both operands, then adds/subtracts in
// one cycle or multiplies/divides bit-serially, with a start/busy/done handshake.
module calc_engine
  import calc_engine_pkg::*;
#(
  parameter  int DIGITS = 2,
  localparam int OPW    = $clog2(10 ** DIGITS),
  localparam int RES_W  = 2 * OPW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a_bcd,
  input  logic [4*DIGITS-1:0] b_bcd,
  input  logic [7:0]          op,
  output logic                busy,
  output logic                done,
  output logic [RES_W-1:0]    result,
  output logic [OPW-1:0]      rem,
  output logic                neg,
  output logic                err
);

  localparam int CNT_W = $clog2(OPW + 1);

  state_e              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [OPW-1:0]      mpl_q, mpl_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic [OPW-1:0]      rem_q, rem_d;
  logic                neg_q, neg_d, err_q, err_d;

  logic [4*DIGITS-1:0] bcd_in  [2];
  logic [OPW-1:0]      bin     [2];
  logic [OPW-1:0]      bin_nxt [2];
  logic                bad_nxt [2];
  logic                accept, conv_last, work_last, conv_err;
  logic [OPW:0]        trial;
  logic                trial_ge;
  logic [OPW-1:0]      part;

  assign bcd_in[0] = a_bcd;
  assign bcd_in[1] = b_bcd;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_conv
    bcd2bin_seq #(.DIGITS(DIGITS)) u_conv (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept),
      .step_i    (state_q == CONV),
      .bcd_i     (bcd_in[gi]),
      .bin_o     (bin[gi]),
      .bin_nxt_o (bin_nxt[gi]),
      .bad_nxt_o (bad_nxt[gi])
    );
  end

  assign accept    = (state_q == IDLE) && start;
  assign conv_last = (state_q == CONV) && (cnt_q == CNT_W'(DIGITS - 1));
  assign work_last = (cnt_q == CNT_W'(OPW - 1));
  assign conv_err  = bad_nxt[0] || bad_nxt[1] || !op_valid(op_q) ||
                     ((op_q == OP_D_IVID) && (bin_nxt[1] == '0));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ERR is the terminal state for rejected requests: it pulses done itself,
  // so an error completes one cycle earlier than a successful add/sub.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CONV;
      CONV: begin
        if (conv_last) begin
          if (conv_err)                  state_d = ERR;
          else if (op_q == OP_F_MULT)    state_d = MUL;
          else if (op_q == OP_D_IVID)    state_d = DIV;
          else                           state_d = EXEC;
        end
      end
      EXEC:     state_d = DONE;
      MUL, DIV: if (work_last) state_d = DONE;
      ERR:      state_d = IDLE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CONV) || (state_q == EXEC) ||
           (state_q == MUL)  || (state_q == DIV);
    done = (state_q == DONE) || (state_q == ERR);
  end

  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mpl_d    = mpl_q;
    result_d = result_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    err_d    = err_q;
    trial    = {acc_q[OPW-1:0], mpl_q[OPW-1]};
    trial_ge = trial >= {1'b0, bin[1]};
    part     = trial_ge ? OPW'(trial - {1'b0, bin[1]}) : trial[OPW-1:0];
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          cnt_d    = '0;
          result_d = '0;
          rem_d    = '0;
          neg_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
      CONV: begin
        cnt_d = cnt_q + 1'b1;
        if (conv_last) begin
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = RES_W'(bin_nxt[0]);
          // Divide shifts the dividend out of mpl while the quotient shifts in.
          mpl_d   = (op_q == OP_D_IVID) ? bin_nxt[0] : bin_nxt[1];
          err_d   = conv_err;
        end
      end
      EXEC: begin
        if (op_q == OP_A_ADD) begin
          result_d = RES_W'(bin[0]) + RES_W'(bin[1]);
        end else if (bin[0] >= bin[1]) begin
          result_d = RES_W'(bin[0] - bin[1]);
        end else begin
          result_d = RES_W'(bin[1] - bin[0]);
          neg_d    = 1'b1;
        end
      end
      MUL: begin
        cnt_d   = cnt_q + 1'b1;
        if (mpl_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mpl_d   = mpl_q >> 1;
        if (work_last) result_d = acc_d;
      end
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = RES_W'(part);
        mpl_d = {mpl_q[OPW-2:0], trial_ge};
        if (work_last) begin
          result_d = RES_W'(mpl_d);
          rem_d    = part;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mpl_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mpl_q    <= mpl_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign rem    = rem_q;
  assign neg    = neg_q;
  assign err    = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine (DIGITS=2): expected results are queued
// when an operation is started and checked when done pulses.
module tb_calc_engine;
  import calc_engine_pkg::*;

  localparam int DIGITS = 2;
  localparam int OPW    = 7;
  localparam int RES_W  = 14;

  typedef struct {
    int res;
    int rem;
    bit neg;
    bit err;
    int lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       a_bcd = '0;
  logic [7:0]       b_bcd = '0;
  logic [7:0]       op = '0;
  logic             busy, done, neg, err;
  logic [RES_W-1:0] result;
  logic [OPW-1:0]   rem;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   busy_cnt = 0;
  exp_t sb_q[$];

  calc_engine #(.DIGITS(DIGITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_bcd  (a_bcd),
    .b_bcd  (b_bcd),
    .op     (op),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rem    (rem),
    .neg    (neg),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
    exp_t e;
    int   av, bv;
    bit   bad;
    e   = '{res: 0, rem: 0, neg: 1'b0, err: 1'b0, lat: 0};
    bad = (a[7:4] > 9) || (a[3:0] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
    av  = 10 * int'(a[7:4]) + int'(a[3:0]);
    bv  = 10 * int'(b[7:4]) + int'(b[3:0]);
    if (bad || !(o inside {OP_A_ADD, OP_B_SUB, OP_F_MULT, OP_D_IVID}) ||
        (o == OP_D_IVID && bv == 0)) begin
      e.err = 1'b1;
      e.lat = DIGITS + 1;
      return e;
    end
    case (o)
      OP_A_ADD: begin e.res = av + bv; e.lat = DIGITS + 2; end
      OP_B_SUB: begin
        e.neg = (av < bv);
        e.res = (av >= bv) ? av - bv : bv - av;
        e.lat = DIGITS + 2;
      end
      OP_F_MULT: begin e.res = av * bv; e.lat = DIGITS + OPW + 1; end
      default: begin e.res = av / bv; e.rem = av % bv; e.lat = DIGITS + OPW + 1; end
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o, input bit track);
    @(negedge clk);
    a_bcd = a;
    b_bcd = b;
    op    = o;
    start = 1'b1;
    if (track) sb_q.push_back(model(a, b, o));
    @(posedge clk);
    #1;
    start_cyc = cyc;
    busy_cnt  = 0;
    start     = 1'b0;
    // Scramble inputs: the engine must work from its captured copies.
    a_bcd = 8'($urandom);
    b_bcd = 8'($urandom);
    op    = 8'($urandom);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      check_eq("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && busy) busy_cnt++;
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", done, 0);
      end else begin
        e = sb_q.pop_front();
        $display("txn done: result=%0d rem=%0d neg=%0b err=%0b latency=%0d busy=%0d",
                 result, rem, neg, err, cyc - start_cyc + 1, busy_cnt);
        check_eq("result",  result, e.res);
        check_eq("rem",     rem, e.rem);
        check_eq("neg",     neg, e.neg);
        check_eq("err",     err, e.err);
        check_eq("latency", cyc - start_cyc + 1, e.lat);
        check_eq("busy_cycles", busy_cnt, e.lat - 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ops [4];
    logic [7:0] ra, rb;
    ops[0] = OP_A_ADD; ops[1] = OP_B_SUB; ops[2] = OP_F_MULT; ops[3] = OP_D_IVID;

    repeat (3) @(negedge clk);
    check_eq("rst_busy",   busy, 0);
    check_eq("rst_done",   done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_err",    err, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(8'h12, 8'h34, OP_A_ADD, 1'b1);  wait_drain();
    repeat (3) @(negedge clk);
    check_eq("hold_result", result, 46);
    run_op(8'h05, 8'h17, OP_B_SUB, 1'b1);  wait_drain();
    run_op(8'h17, 8'h05, OP_B_SUB, 1'b1);  wait_drain();
    run_op(8'h99, 8'h99, OP_F_MULT, 1'b1); wait_drain();
    run_op(8'h97, 8'h07, OP_D_IVID, 1'b1); wait_drain();
    run_op(8'h42, 8'h00, OP_D_IVID, 1'b1); wait_drain();
    run_op(8'h1A, 8'h03, OP_A_ADD, 1'b1);  wait_drain();
    run_op(8'h21, 8'h03, 8'h00, 1'b1);     wait_drain();

    // A second start while busy must be dropped without a second done.
    run_op(8'h12, 8'h34, OP_F_MULT, 1'b1);
    @(negedge clk); start = 1'b1; a_bcd = 8'h01; b_bcd = 8'h01; op = OP_A_ADD;
    @(negedge clk); start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);

    // Abort a multiply midway with a one-clock reset.
    run_op(8'h99, 8'h99, OP_F_MULT, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("pre_abort_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("abort_busy",   busy, 0);
    check_eq("abort_done",   done, 0);
    check_eq("abort_result", result, 0);
    repeat (12) @(negedge clk);
    run_op(8'h03, 8'h04, OP_F_MULT, 1'b1); wait_drain();

    for (int i = 0; i < 8; i++) begin
      ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_op(ra, rb, ops[$urandom_range(0, 3)], 1'b1);
      wait_drain();
    end

    repeat (5) @(negedge clk);
    check_eq("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
